conv_transpose2d_stream: RTL and testbench



---
 rtl/conv_transpose2d_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_conv_transpose2d_stream.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_transpose2d_stream.sv
// rtl/conv_transpose2d_stream.sv - streaming single-channel transposed 2D convolution engine
//
// Purpose:
//   Accepts an IN_ROWS x IN_COLS feature map as a raster-order pixel stream.
//   Each pixel is multiplied by every kernel tap and scattered into an
//   OUT_ROWS x OUT_COLS accumulator array. The finished map is drained in
//   raster order after bias add, arithmetic right shift and saturation.
//
// Ports:
//   clk                rising-edge clock
//   rst_n              asynchronous active-low reset
//   kw_en/kw_addr/kw_data
//                      kernel tap write (addr < NTAPS) or bias write (addr == NTAPS)
//   kw_busy            high while writes are dropped (SCATTER, DRAIN)
//   in_valid/in_ready/in_data
//                      input pixel stream, raster order
//   out_valid/out_ready/out_data/out_last
//                      output pixel stream, out_last with the final pixel

module conv_transpose2d_stream #(
  parameter int IN_ROWS     = 4,
  parameter int IN_COLS     = 4,
  parameter int KERNEL_ROWS = 3,
  parameter int KERNEL_COLS = 3,
  parameter int STRIDE      = 2,
  parameter int DATA_SIZE   = 8,
  parameter int ACC_W       = 20,
  parameter int FRAC_BITS   = 0
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            kw_en,
  input  logic [$clog2(KERNEL_ROWS*KERNEL_COLS+1)-1:0]    kw_addr,
  input  logic [DATA_SIZE-1:0]                            kw_data,
  output logic                                            kw_busy,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DATA_SIZE-1:0]                            in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DATA_SIZE-1:0]                            out_data,
  output logic                                            out_last
);

  localparam int OUT_ROWS = (IN_ROWS - 1) * STRIDE + KERNEL_ROWS;
  localparam int OUT_COLS = (IN_COLS - 1) * STRIDE + KERNEL_COLS;
  localparam int NTAPS    = KERNEL_ROWS * KERNEL_COLS;
  localparam int OUT_N    = OUT_ROWS * OUT_COLS;
  localparam int KW_AW    = $clog2(NTAPS + 1);
  localparam int CW       = 16;
  localparam int PW       = 2 * DATA_SIZE;
  // Headroom for the bias add and the pre-shift left shift of the bias.
  localparam int SW       = ACC_W + FRAC_BITS + 2;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_ACCEPT  = 2'd1,
    S_SCATTER = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DATA_SIZE-1:0] r_kern [NTAPS];
  logic signed [DATA_SIZE-1:0] r_bias;
  logic signed [DATA_SIZE-1:0] r_pix;
  logic signed [ACC_W-1:0]     r_acc [OUT_N];

  logic [CW-1:0] r_clr_idx;
  logic [CW-1:0] r_in_row;
  logic [CW-1:0] r_in_col;
  logic [CW-1:0] r_kr;
  logic [CW-1:0] r_kc;
  logic [CW-1:0] r_out_idx;
  logic          r_out_valid;
  logic          r_out_last;
  logic [DATA_SIZE-1:0] r_out_data;

  logic                        w_clr_done;
  logic                        w_last_tap;
  logic                        w_last_pix;
  logic [CW-1:0]               w_tap_idx;
  logic [CW-1:0]               w_acc_addr;
  logic [CW-1:0]               w_rd_idx;
  logic [CW-1:0]               w_acc_raddr;
  logic [CW-1:0]               w_acc_waddr;
  logic                        w_acc_we;
  logic signed [ACC_W-1:0]     w_acc_rd;
  logic signed [ACC_W-1:0]     w_acc_wdata;
  logic signed [DATA_SIZE-1:0] w_tap;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [SW-1:0]        w_sum;
  logic signed [SW-1:0]        w_shr;
  logic [DATA_SIZE-1:0]        w_sat;

  assign w_clr_done = (r_clr_idx == CW'(OUT_N - 1));
  assign w_last_tap = (r_kr == CW'(KERNEL_ROWS - 1)) && (r_kc == CW'(KERNEL_COLS - 1));
  assign w_last_pix = (r_in_row == CW'(IN_ROWS - 1)) && (r_in_col == CW'(IN_COLS - 1));
  assign w_tap_idx  = CW'(r_kr * KERNEL_COLS + r_kc);
  assign w_acc_addr = CW'((r_in_row * STRIDE + r_kr) * OUT_COLS + r_in_col * STRIDE + r_kc);

  // During DRAIN the read index runs one ahead of the presented beat so the
  // next output can be loaded on the same edge that retires the current one.
  assign w_rd_idx    = r_out_valid ? (r_out_idx + CW'(1)) : r_out_idx;
  assign w_acc_raddr = (r_state == S_DRAIN) ? w_rd_idx : w_acc_addr;

  assign w_acc_we    = (r_state == S_CLEAR) || (r_state == S_SCATTER);
  assign w_acc_waddr = (r_state == S_CLEAR) ? r_clr_idx : w_acc_addr;
  assign w_prod      = r_pix * w_tap;
  assign w_prod_ext  = ACC_W'(w_prod);
  assign w_acc_wdata = (r_state == S_CLEAR) ? '0 : (w_acc_rd + w_prod_ext);

  assign w_sum = SW'(w_acc_rd) + (SW'(r_bias) <<< FRAC_BITS);
  assign w_shr = w_sum >>> FRAC_BITS;
  assign w_sat = (w_shr > SAT_MAX) ? SAT_MAX[DATA_SIZE-1:0] :
                 (w_shr < SAT_MIN) ? SAT_MIN[DATA_SIZE-1:0] : w_shr[DATA_SIZE-1:0];

  assign in_ready  = (r_state == S_ACCEPT);
  assign kw_busy   = (r_state == S_SCATTER) || (r_state == S_DRAIN);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  always_comb begin
    w_tap = '0;
    for (int t = 0; t < NTAPS; t++) begin
      if (w_tap_idx == CW'(t)) w_tap = r_kern[t];
    end
  end

  always_comb begin
    w_acc_rd = '0;
    for (int i = 0; i < OUT_N; i++) begin
      if (w_acc_raddr == CW'(i)) w_acc_rd = r_acc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:   if (w_clr_done) w_next = S_ACCEPT;
      S_ACCEPT:  if (in_valid) w_next = S_SCATTER;
      S_SCATTER: if (w_last_tap) w_next = w_last_pix ? S_DRAIN : S_ACCEPT;
      S_DRAIN:   if (r_out_valid && out_ready && r_out_last) w_next = S_CLEAR;
      default:   w_next = S_CLEAR;
    endcase
  end

  // Accumulators carry no reset; CLEAR sweeps them before every frame.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUT_N; i++) begin
      if (w_acc_we && (w_acc_waddr == CW'(i))) r_acc[i] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTAPS; t++) r_kern[t] <= '0;
      r_bias <= '0;
    end else if (kw_en && ((r_state == S_CLEAR) || (r_state == S_ACCEPT))) begin
      for (int t = 0; t < NTAPS; t++) begin
        if (kw_addr == KW_AW'(t)) r_kern[t] <= kw_data;
      end
      if (kw_addr == KW_AW'(NTAPS)) r_bias <= kw_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx   <= '0;
      r_in_row    <= '0;
      r_in_col    <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_pix       <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= w_clr_done ? '0 : (r_clr_idx + CW'(1));
        end
        S_ACCEPT: begin
          if (in_valid) r_pix <= in_data;
        end
        S_SCATTER: begin
          // Tap counters wrap into the input position counters, which then
          // name the next pixel to arrive.
          if (r_kc == CW'(KERNEL_COLS - 1)) begin
            r_kc <= '0;
            if (r_kr == CW'(KERNEL_ROWS - 1)) begin
              r_kr <= '0;
              if (r_in_col == CW'(IN_COLS - 1)) begin
                r_in_col <= '0;
                r_in_row <= (r_in_row == CW'(IN_ROWS - 1)) ? '0 : (r_in_row + CW'(1));
              end else begin
                r_in_col <= r_in_col + CW'(1);
              end
            end else begin
              r_kr <= r_kr + CW'(1);
            end
          end else begin
            r_kc <= r_kc + CW'(1);
          end
        end
        S_DRAIN: begin
          if (!r_out_valid || (out_ready && !r_out_last)) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_rd_idx;
            r_out_data  <= w_sat;
            r_out_last  <= (w_rd_idx == CW'(OUT_N - 1));
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_transpose2d_stream.sv
// tb/tb_conv_transpose2d_stream.sv - self-checking bench for conv_transpose2d_stream
module tb_conv_transpose2d_stream;

  localparam int NI = 5;

  // Instance configurations:
  //   0: 2x2 in, 2x2 kernel, stride 1   1: 2x2 in, 2x2 kernel, stride 2
  //   2: 1x1 in, 1x1 kernel             3: 1x1 in, 1x1 kernel, FRAC_BITS 7
  //   4: 4x4 in, 3x3 kernel, stride 2
  function automatic int f_in(int g);
    return (g <= 1) ? 2 : ((g == 4) ? 4 : 1);
  endfunction
  function automatic int f_k(int g);
    return (g <= 1) ? 2 : ((g == 4) ? 3 : 1);
  endfunction
  function automatic int f_st(int g);
    return ((g == 1) || (g == 4)) ? 2 : 1;
  endfunction
  function automatic int f_fb(int g);
    return (g == 3) ? 7 : 0;
  endfunction
  function automatic int f_out(int g);
    return (f_in(g) - 1) * f_st(g) + f_k(g);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      rst_n, kw_en, kw_busy, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [NI-1:0][3:0] kw_addr;
  logic [NI-1:0][7:0] kw_data, in_data, out_data;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NT = f_k(g) * f_k(g);
    localparam int AW = $clog2(NT + 1);
    conv_transpose2d_stream #(
      .IN_ROWS(f_in(g)), .IN_COLS(f_in(g)),
      .KERNEL_ROWS(f_k(g)), .KERNEL_COLS(f_k(g)),
      .STRIDE(f_st(g)), .DATA_SIZE(8), .ACC_W(20), .FRAC_BITS(f_fb(g))
    ) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .kw_en(kw_en[g]), .kw_addr(kw_addr[g][AW-1:0]), .kw_data(kw_data[g]), .kw_busy(kw_busy[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]), .out_last(out_last[g])
    );
  end

  int checks = 0;
  int errors = 0;

  int pix_a [16];
  int kern_a [9];
  int bias_v;
  int exp_q [$];
  int cur = -1;
  logic [3:0] pat = 4'b1001;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: direct scatter over the output grid, then bias/shift/clamp.
  task automatic build_model(int g);
    int n, k, s, f, o, v;
    int acc [81];
    n = f_in(g); k = f_k(g); s = f_st(g); f = f_fb(g); o = f_out(g);
    for (int i = 0; i < 81; i++) acc[i] = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        for (int a = 0; a < k; a++)
          for (int b = 0; b < k; b++)
            acc[(i*s + a)*o + j*s + b] += pix_a[i*n + j] * kern_a[a*k + b];
    exp_q.delete();
    for (int i = 0; i < o*o; i++) begin
      v = (acc[i] + (bias_v <<< f)) >>> f;
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
      exp_q.push_back(v);
    end
  endtask

  always @(negedge clk) begin : compare
    int g, d;
    static int prev_d = 0;
    static int prev_l = 0;
    static bit prev_stall = 1'b0;
    g = cur;
    if (g < 0) begin
      prev_stall = 1'b0;
    end else begin
      d = int'($signed(out_data[g]));
      check("ready_valid_excl", int'(in_ready[g] && out_valid[g]), 0);
      if (prev_stall) begin
        check("stall_valid", int'(out_valid[g]), 1);
        check("stall_data", d, prev_d);
        check("stall_last", int'(out_last[g]), prev_l);
      end
      if (out_valid[g] && out_ready[g]) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          check("beat_data", d, exp_q.pop_front());
          check("beat_last", int'(out_last[g]), int'(exp_q.size() == 0));
        end
      end
      prev_stall = out_valid[g] && !out_ready[g];
      prev_d = d;
      prev_l = int'(out_last[g]);
    end
  end

  task automatic do_reset(int g, bit hold_valid, int first_pix);
    int n = 0;
    rst_n[g] = 1'b0; kw_en[g] = 1'b0; out_ready[g] = 1'b0;
    in_valid[g] = hold_valid; in_data[g] = 8'(first_pix);
    #1;
    check("rst_in_ready", int'(in_ready[g]), 0);
    check("rst_out_valid", int'(out_valid[g]), 0);
    check("rst_out_last", int'(out_last[g]), 0);
    check("rst_out_data", int'(out_data[g]), 0);
    check("rst_kw_busy", int'(kw_busy[g]), 0);
    @(posedge clk); #1;
    rst_n[g] = 1'b1;
    while (!in_ready[g] && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("clear_cycles", n, f_out(g) * f_out(g));
  endtask

  task automatic write_kw(int g, int addr, int data);
    kw_en[g] = 1'b1; kw_addr[g] = 4'(addr); kw_data[g] = 8'(data);
    @(posedge clk); #1;
    kw_en[g] = 1'b0;
  endtask

  task automatic send_pixel(int g, int v);
    int t = 0;
    in_data[g] = 8'(v); in_valid[g] = 1'b1;
    while (!in_ready[g] && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_wait", int'(t < 500), 1);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic run_frame(int g, bit stall, int start_p, int abort_after, bit poke);
    int n, cyc;
    n = f_in(g);
    cur = g;
    for (int p = start_p; p < n*n; p++) begin
      send_pixel(g, pix_a[p]);
      if (poke && p == start_p) begin
        check("kw_busy_scatter", int'(kw_busy[g]), 1);
        write_kw(g, 0, 50);
      end
      if (p == abort_after) begin
        @(posedge clk); #1;
        check("kw_busy_abort", int'(kw_busy[g]), 1);
        rst_n[g] = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready[g]), 0);
        check("abort_kw_busy", int'(kw_busy[g]), 0);
        check("abort_out_valid", int'(out_valid[g]), 0);
        cur = -1;
        exp_q.delete();
        return;
      end
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk); #1;
      out_ready[g] = stall ? pat[cyc % 4] : 1'b1;
      cyc++;
    end
    check("drain_done", exp_q.size(), 0);
    out_ready[g] = 1'b0;
    cur = -1;
  endtask

  task automatic set_all(int pv, int kv, int b);
    for (int i = 0; i < 16; i++) pix_a[i] = pv;
    for (int i = 0; i < 9; i++) kern_a[i] = kv;
    bias_v = b;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit1 [9];
    int lit2 [16];
    lit1 = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    lit2 = '{1, -1, 2, -2, 2, 0, 4, 0, 3, -3, 4, -4, 6, 0, 8, 0};
    rst_n = '0; kw_en = '0; kw_addr = '0; kw_data = '0;
    in_valid = '0; in_data = '0; out_ready = '0;

    // Overlapping stride-1 scatter, all ones.
    do_reset(0, 1'b0, 0);
    for (int t = 0; t < 4; t++) write_kw(0, t, 1);
    set_all(1, 1, 0);
    build_model(0);
    for (int i = 0; i < 9; i++) check("model_case1", exp_q[i], lit1[i]);
    run_frame(0, 1'b0, 0, -1, 1'b0);

    // Non-overlapping stride-2 tiles, stalled drain.
    do_reset(1, 1'b0, 0);
    write_kw(1, 0, 1); write_kw(1, 1, -1); write_kw(1, 2, 2); write_kw(1, 3, 0);
    set_all(0, 0, 0);
    kern_a[0] = 1; kern_a[1] = -1; kern_a[2] = 2; kern_a[3] = 0;
    for (int i = 0; i < 4; i++) pix_a[i] = i + 1;
    build_model(1);
    for (int i = 0; i < 16; i++) check("model_case2", exp_q[i], lit2[i]);
    run_frame(1, 1'b1, 0, -1, 1'b0);

    // Saturation at both rails, back-to-back frames without reset.
    do_reset(2, 1'b0, 0);
    write_kw(2, 0, 127);
    set_all(127, 0, 0); kern_a[0] = 127;
    build_model(2);
    check("model_sat_hi", exp_q[0], 127);
    run_frame(2, 1'b0, 0, -1, 1'b0);
    pix_a[0] = -128;
    build_model(2);
    check("model_sat_lo", exp_q[0], -128);
    run_frame(2, 1'b0, 0, -1, 1'b0);

    // Fixed-point shift: 10 * 64 >>> 7.
    do_reset(3, 1'b0, 0);
    write_kw(3, 0, 64);
    set_all(10, 0, 0); kern_a[0] = 64;
    build_model(3);
    check("model_frac", exp_q[0], 5);
    run_frame(3, 1'b0, 0, -1, 1'b0);

    // Bias only; out-of-range address and write during SCATTER are dropped.
    do_reset(4, 1'b0, 0);
    write_kw(4, 9, 5);
    write_kw(4, 12, 7);
    set_all(0, 0, 5);
    for (int i = 0; i < 16; i++) pix_a[i] = i - 8;
    build_model(4);
    check("model_bias_first", exp_q[0], 5);
    check("model_bias_last", exp_q[80], 5);
    run_frame(4, 1'b0, 0, -1, 1'b1);

    // in_valid held through CLEAR; tap write in the handshake cycle; stalled drain.
    set_all(0, 0, 0);
    for (int i = 0; i < 16; i++) pix_a[i] = 3*i - 20;
    kern_a[4] = 2;
    do_reset(4, 1'b1, pix_a[0]);
    kw_en[4] = 1'b1; kw_addr[4] = 4'd4; kw_data[4] = 8'd2;
    @(posedge clk); #1;
    kw_en[4] = 1'b0; in_valid[4] = 1'b0;
    build_model(4);
    check("model_centre", exp_q[10], -40);
    run_frame(4, 1'b1, 1, -1, 1'b0);

    // Abort mid-SCATTER of pixel 3, then verify cleared kernel and clean rerun.
    do_reset(0, 1'b0, 0);
    for (int t = 0; t < 4; t++) write_kw(0, t, 1);
    set_all(1, 1, 0);
    run_frame(0, 1'b0, 0, 2, 1'b0);
    do_reset(0, 1'b0, 0);
    set_all(1, 0, 0);
    build_model(0);
    run_frame(0, 1'b0, 0, -1, 1'b0);
    for (int t = 0; t < 4; t++) write_kw(0, t, 1);
    set_all(1, 1, 0);
    build_model(0);
    run_frame(0, 1'b1, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
